// File: rtl/pixfifo_fill_ctrl.sv
// Read-DMA that keeps the HDMI pixel FIFO fed from the SDRAM frame buffer.
// Raster-order Avalon-MM bursts, throttled by FIFO level plus words in flight.
module pixfifo_fill_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int BURST_LEN     = 16,
  parameter int FIFO_DEPTH    = 512,
  parameter int PREFILL_WORDS = 256,
  parameter int FRAME_WORDS   = 1036800
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [ADDR_WIDTH-1:0]           frame_base_i,
  input  logic                            frame_base_wr_i,
  output logic [ADDR_WIDTH-1:0]           avm_address_o,
  output logic                            avm_read_o,
  output logic [$clog2(BURST_LEN):0]      avm_burstcount_o,
  input  logic                            avm_waitrequest_i,
  input  logic                            avm_readdatavalid_i,
  input  logic [DATA_WIDTH-1:0]           avm_readdata_i,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_wrusedw_i,
  output logic                            fifo_wrreq_o,
  output logic [DATA_WIDTH-1:0]           fifo_data_o,
  output logic                            fifo_flush_o,
  output logic                            pixel_ready_o,
  output logic                            frame_done_o
);

  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int IW  = $clog2(FRAME_WORDS + 1);
  localparam int SW  = LW + 2;
  localparam int ASH = $clog2(DATA_WIDTH / 8);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARB   = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_FEND  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_base_q, cur_base_q;
  logic [IW-1:0]         word_idx_q, word_idx_d;
  logic [LW-1:0]         outst_q, outst_d;
  logic                  wrreq_q, done_q, ready_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [IW-1:0]  remain;
  logic [BCW-1:0] bc;
  logic           in_req, accept, fits, frame_end, beat, writing;

  assign remain    = IW'(FRAME_WORDS) - word_idx_q;
  assign bc        = (remain < IW'(BURST_LEN)) ? BCW'(remain)
                                               : BCW'(BURST_LEN);
  assign in_req    = (state_q == S_REQ);
  assign accept    = in_req && !avm_waitrequest_i;
  assign frame_end = (word_idx_q == IW'(FRAME_WORDS));
  assign beat      = avm_readdatavalid_i && (outst_q != '0);
  assign writing   = (state_q != S_DRAIN) && (state_q != S_IDLE);

  // Space check counts words already in flight, so a lagging level is safe.
  assign fits = (SW'(fifo_wrusedw_i) + SW'(outst_q) + SW'(bc))
                <= SW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    outst_d    = outst_q + (accept ? LW'(bc) : '0) - (beat ? LW'(1) : '0);
    unique case (state_q)
      S_IDLE:  if (enable_i) state_d = S_START;
      S_START: begin
        word_idx_d = '0;
        state_d    = S_ARB;
      end
      S_ARB: begin
        if (!enable_i)     state_d = S_DRAIN;
        else if (frame_end) state_d = S_FEND;
        else if (fits)      state_d = S_REQ;
      end
      S_REQ: begin
        if (accept) begin
          word_idx_d = word_idx_q + IW'(bc);
          state_d    = S_ARB;
        end
      end
      S_FEND: begin
        if (outst_q == '0) state_d = enable_i ? S_START : S_DRAIN;
      end
      S_DRAIN: if (outst_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pend_base_q <= '0;
      cur_base_q  <= '0;
      word_idx_q  <= '0;
      outst_q     <= '0;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      outst_q    <= outst_d;
      if (frame_base_wr_i) pend_base_q <= frame_base_i;
      if (state_q == S_START) cur_base_q <= pend_base_q;
      wrreq_q <= avm_readdatavalid_i && writing;
      if (avm_readdatavalid_i) data_q <= avm_readdata_i;
      done_q <= beat && writing && frame_end && (outst_q == LW'(1));
      if (!enable_i)
        ready_q <= 1'b0;
      else if (writing && (fifo_wrusedw_i >= LW'(PREFILL_WORDS)))
        ready_q <= 1'b1;
    end
  end

  assign avm_read_o       = in_req;
  assign avm_address_o    = in_req ? cur_base_q + (ADDR_WIDTH'(word_idx_q) << ASH)
                                   : '0;
  assign avm_burstcount_o = in_req ? bc : '0;
  assign fifo_flush_o     = (state_q == S_IDLE);
  assign fifo_wrreq_o     = wrreq_q;
  assign fifo_data_o      = data_q;
  assign pixel_ready_o    = ready_q;
  assign frame_done_o     = done_q;

endmodule

// File: tb/tb_pixfifo_fill_ctrl.sv
// Bench for pixfifo_fill_ctrl: vector table, randomized slave/FIFO model,
// and hand sequences for stall, drain and reset corners.
module tb_pixfifo_fill_ctrl;

  localparam int FW = 600;
  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] frame_base_i;
  logic        frame_base_wr_i;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic [4:0]  avm_burstcount_o;
  logic        avm_waitrequest_i;
  logic        avm_readdatavalid_i;
  logic [63:0] avm_readdata_i;
  logic [9:0]  fifo_wrusedw_i;
  logic        fifo_wrreq_o;
  logic [63:0] fifo_data_o;
  logic        fifo_flush_o;
  logic        pixel_ready_o;
  logic        frame_done_o;

  always #5 clk = ~clk;

  pixfifo_fill_ctrl #(.FRAME_WORDS(FW)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .frame_base_i(frame_base_i),
    .frame_base_wr_i(frame_base_wr_i),
    .avm_address_o(avm_address_o),
    .avm_read_o(avm_read_o),
    .avm_burstcount_o(avm_burstcount_o),
    .avm_waitrequest_i(avm_waitrequest_i),
    .avm_readdatavalid_i(avm_readdatavalid_i),
    .avm_readdata_i(avm_readdata_i),
    .fifo_wrusedw_i(fifo_wrusedw_i),
    .fifo_wrreq_o(fifo_wrreq_o),
    .fifo_data_o(fifo_data_o),
    .fifo_flush_o(fifo_flush_o),
    .pixel_ready_o(pixel_ready_o),
    .frame_done_o(frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        wt;
    logic        bwr;
    logic        rd;
    logic [31:0] addr;
    logic [4:0]  bc;
    logic        fl;
  } vec_t;

  vec_t tbl[14];

  // Reference model state
  logic [63:0] beatq[$];
  logic [63:0] wrq[$];
  int          lvl, k, req_words, beats_wr, frames;
  logic [31:0] fb, pend_m;
  bit          rdy_exp, drain_on;
  int          wait_pct, rdv_pct, drain_pct;

  task automatic model_init(input logic [31:0] base);
    beatq.delete();
    wrq.delete();
    lvl = 0; k = 0; req_words = 0; beats_wr = 0; frames = 0;
    fb = base; pend_m = base; rdy_exp = 0;
  endtask

  task automatic cyc();
    logic        acc, dexp;
    int          bce;
    logic [31:0] ae;
    @(negedge clk);
    bce = (FW - 16 * k < 16) ? FW - 16 * k : 16;
    ae  = fb + 32'(k * 128);
    acc = avm_read_o && !avm_waitrequest_i;
    if (avm_read_o) begin
      chk("cmd_addr", avm_address_o, ae);
      chk("cmd_bc", avm_burstcount_o, bce);
    end
    if (acc) begin
      for (int i = 0; i < bce; i++) beatq.push_back({$urandom, $urandom});
      req_words += bce;
      k++;
      if (16 * k >= FW) begin
        k  = 0;
        fb = pend_m;
      end
    end
    dexp = 1'b0;
    if (fifo_wrreq_o) begin
      chk("fifo_ovf", lvl < 512, 1);
      if (wrq.size() > 0) chk("wr_data", fifo_data_o, wrq.pop_front());
      else chk("wr_extra", fifo_wrreq_o, 0);
      lvl++;
      beats_wr++;
      dexp = (beats_wr % FW) == 0;
    end
    if (avm_readdatavalid_i) wrq.push_back(avm_readdata_i);
    if (fifo_wrreq_o || frame_done_o) chk("frame_done", frame_done_o, dexp);
    if (frame_done_o) frames++;
    chk("ready", pixel_ready_o, rdy_exp);
    if (!enable_i) rdy_exp = 0;
    else if (fifo_wrusedw_i >= 10'd256) rdy_exp = 1;
    if (fifo_flush_o) lvl = 0;
    if (drain_on && lvl > 0 && $urandom_range(99) < drain_pct) lvl--;
    @(posedge clk);
    #1;
    avm_waitrequest_i = ($urandom_range(99) < wait_pct);
    if (beatq.size() > 0 && $urandom_range(99) < rdv_pct) begin
      avm_readdatavalid_i = 1'b1;
      avm_readdata_i      = beatq.pop_front();
    end else begin
      avm_readdatavalid_i = 1'b0;
    end
    fifo_wrusedw_i = 10'(lvl);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_read"}, avm_read_o, 0);
    chk({tag, "_addr"}, avm_address_o, 0);
    chk({tag, "_bc"}, avm_burstcount_o, 0);
    chk({tag, "_wrreq"}, fifo_wrreq_o, 0);
    chk({tag, "_data"}, fifo_data_o, 0);
    chk({tag, "_flush"}, fifo_flush_o, 1);
    chk({tag, "_ready"}, pixel_ready_o, 0);
    chk({tag, "_done"}, frame_done_o, 0);
  endtask

  initial begin
    int  nwr;
    bit  found, bwritten;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    for (int i = 4; i < 9; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3000_0000, 5'd16, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3000_0000, 5'd16, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3000_0080, 5'd16, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3000_0100, 5'd16, 1'b0};

    rst_i = 1'b1;
    enable_i = 1'b0;
    frame_base_i = 32'h3000_0000;
    frame_base_wr_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    avm_readdatavalid_i = 1'b0;
    avm_readdata_i = '0;
    fifo_wrusedw_i = '0;
    wait_pct = 0; rdv_pct = 0; drain_pct = 0; drain_on = 0;
    model_init(BASE_A);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    rst_i = 1'b0;

    // Startup, waitrequest hold and second command address
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      enable_i          = tbl[i].en;
      avm_waitrequest_i = tbl[i].wt;
      frame_base_wr_i   = tbl[i].bwr;
      @(negedge clk);
      chk($sformatf("tv%0d_read", i), avm_read_o, tbl[i].rd);
      chk($sformatf("tv%0d_flush", i), fifo_flush_o, tbl[i].fl);
      if (tbl[i].rd) begin
        chk($sformatf("tv%0d_addr", i), avm_address_o, tbl[i].addr);
        chk($sformatf("tv%0d_bc", i), avm_burstcount_o, tbl[i].bc);
      end
    end

    // Asynchronous reset while a command is pending
    #2 rst_i = 1'b1;
    #1 chk_reset_outs("rst_req");
    enable_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    frame_base_wr_i = 1'b0;

    // Randomized multi-frame run with mid-frame base swap
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    frame_base_i = BASE_A;
    frame_base_wr_i = 1'b1;
    model_init(BASE_A);
    wait_pct = 30; rdv_pct = 75; drain_pct = 70; drain_on = 1;
    cyc();
    frame_base_wr_i = 1'b0;
    enable_i = 1'b1;
    bwritten = 0;
    for (int c = 0; c < 40000 && frames < 3; c++) begin
      if (!bwritten && frames == 0 && k >= 5) begin
        frame_base_i = BASE_B;
        frame_base_wr_i = 1'b1;
        pend_m = BASE_B;
        bwritten = 1;
        cyc();
        frame_base_wr_i = 1'b0;
      end else begin
        cyc();
      end
    end
    chk("frames", frames, 3);
    chk("beats", beats_wr, 3 * FW);

    // Never-drained FIFO: requests must stop at exactly FIFO_DEPTH words
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    enable_i = 1'b0;
    avm_readdatavalid_i = 1'b0;
    fifo_wrusedw_i = '0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    frame_base_i = BASE_A;
    frame_base_wr_i = 1'b1;
    model_init(BASE_A);
    drain_on = 0; wait_pct = 20; rdv_pct = 70;
    cyc();
    frame_base_wr_i = 1'b0;
    enable_i = 1'b1;
    repeat (2000) cyc();
    chk("stall_req_words", req_words, 512);
    chk("stall_level", lvl, 512);
    chk("stall_inflight", beatq.size() + wrq.size(), 0);
    chk("stall_ready", pixel_ready_o, 1);

    // Disable with 12 words outstanding
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    enable_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    avm_readdatavalid_i = 1'b0;
    fifo_wrusedw_i = '0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    enable_i = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (avm_read_o) found = 1;
    end
    chk("drain_cmd_seen", found, 1);
    @(posedge clk);
    #1;
    fifo_wrusedw_i = 10'd512;
    nwr = 0;
    for (int c = 0; c < 8; c++) begin
      avm_readdatavalid_i = (c < 4);
      avm_readdata_i = 64'hA0 + 64'(c);
      @(negedge clk);
      if (fifo_wrreq_o) begin
        chk("pre_data", fifo_data_o, 64'hA0 + 64'(nwr));
        nwr++;
      end
      chk("pre_noread", avm_read_o, 0);
      @(posedge clk);
      #1;
    end
    chk("pre_writes", nwr, 4);
    @(negedge clk);
    chk("pre_ready", pixel_ready_o, 1);
    @(posedge clk);
    #1;
    enable_i = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 16; c++) begin
      avm_readdatavalid_i = (c < 12);
      avm_readdata_i = 64'hB0 + 64'(c);
      @(negedge clk);
      chk($sformatf("drain%0d_wrreq", c), fifo_wrreq_o, 0);
      chk($sformatf("drain%0d_read", c), avm_read_o, 0);
      chk($sformatf("drain%0d_ready", c), pixel_ready_o, 0);
      chk($sformatf("drain%0d_flush", c), fifo_flush_o, c >= 13);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
